vec_mac_unit: RTL and testbench
===============================

VEC_MAC_UNIT -- requirements
Module: vec_mac_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, element/data width in bits (multiple of 8).
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum elements per operation.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have derived parameter LEN_W = clog2(MAX_LEN+1), the length field width.
REQ-005 Port clk_i, input, 1: clock; rising edge.
REQ-006 Port rst_i, input, 1: reset; asynchronous, active-high.
REQ-007 Port start_i, input, 1: operation request; sampled only in IDLE.
REQ-008 Port len_i, input, LEN_W: element count N.
REQ-009 Ports src_a_i, src_b_i, dst_i, input, ADDR_W each: vector A base, vector B base, destination address.
REQ-010 Port mode_i, input, 2: 00 = wrap-accumulate, 01 = saturate-accumulate, 10 = overwrite, 11 = reserved (error).
REQ-011 Ports busy_o (1), done_o (1), err_o (1), result_o (XLEN), outputs: active flag, one-cycle completion pulse, sticky error flag, last value written.
REQ-012 Ports mem_req_o (1), mem_we_o (1), mem_addr_o (ADDR_W), mem_wdata_o (XLEN), outputs: memory request channel.
REQ-013 Ports mem_gnt_i (1), mem_rvalid_i (1), mem_rdata_i (XLEN), inputs: grant, read-data valid, read data.

Function
REQ-014 SHALL implement states IDLE, RD_A, WT_A, RD_B, WT_B, RD_D, WT_D, WR_D, DONE.
REQ-015 In IDLE with start_i=1, SHALL capture all operands and clear the accumulator, element index and err_o.
REQ-016 SHALL raise err_o and go IDLE->DONE with no memory traffic if N=0, N>MAX_LEN, mode_i=11, or any address is not XLEN/8-aligned.
REQ-017 Otherwise, IDLE SHALL go to RD_A.
REQ-018 Element i SHALL be read from base + i*(XLEN/8), i = 0..N-1.
REQ-019 RD_x SHALL assert mem_req_o with addr/we/wdata held stable until mem_gnt_i=1 is sampled, then go to WT_x.
REQ-020 WT_x SHALL wait for mem_rvalid_i=1 (earliest the cycle after the grant); mem_rvalid_i in any other state SHALL be ignored.
REQ-021 WT_A SHALL latch A[i]; WT_B SHALL add signed A[i]*B[i] into acc.
REQ-022 After WT_B, SHALL go to RD_A for i+1 if i<N-1; otherwise to RD_D in modes 00/01, or WR_D in mode 10.
REQ-023 acc SHALL be signed, 2*XLEN+LEN_W bits wide, so it never overflows.
REQ-024 Final value in mode 00 SHALL be the low XLEN bits of acc+D.
REQ-025 Final value in mode 01 SHALL be acc+sext(D) clamped to [-2^(XLEN-1), 2^(XLEN-1)-1].
REQ-026 Final value in mode 10 SHALL be acc truncated to XLEN bits.
REQ-027 WR_D SHALL issue a write (mem_we_o=1) to dst, complete on grant with no rvalid expected, update result_o, then go to DONE.
REQ-028 SHALL keep at most one outstanding request; mem_req_o SHALL be 0 outside the RD_x and WR_D states.
REQ-029 DONE SHALL pulse done_o for exactly one cycle and return to IDLE; busy_o SHALL be 1 in all states except IDLE and DONE.
REQ-030 start_i while busy SHALL be ignored; start_i in DONE SHALL be ignored.
REQ-031 Zero-wait memory (grant same cycle, rvalid next cycle) SHALL give done_o exactly 4N+4 cycles after start is sampled in modes 00/01, and 4N+2 in mode 10.

Reset
REQ-032 On rst_i, SHALL go to IDLE immediately, including mid-operation.
REQ-033 Reset values SHALL be: busy_o, done_o, err_o, mem_req_o, mem_we_o = 0; mem_addr_o, mem_wdata_o, result_o, acc, index = 0.
REQ-034 A grant or rvalid arriving after reset SHALL have no effect; no write SHALL issue after reset.

Structure
REQ-035 Package vec_mac_pkg SHALL hold the state enum, the mode encodings and the clog2 helper.
REQ-036 Combinational sub-module vec_mac_sat SHALL compute the final add and clamp (REQ-024..026) from acc, D and mode.

Verification
REQ-037 XLEN=32, N=3, A={1,2,3}, B={4,5,6}, D=10, mode 00, zero-wait -> dst=42, result_o=42, done_o at cycle 16, err_o=0.
REQ-038 Mode 01, N=2, A={0x7FFFFFFF,0x7FFFFFFF}, B={2,2}, D=0 -> dst=0x7FFFFFFF; same stimulus in mode 00 -> 0xFFFFFFFC.
REQ-039 Mode 10, N=1, A={-3}, B={7}, D=100 -> dst=0xFFFFFFEB, dst never read, done_o at cycle 6.
REQ-040 Random 0-5 cycle grant and rvalid delays, N=16 -> addr/we/wdata stable while mem_req_o=1 and ungranted, result matches model, one request outstanding.
REQ-041 N=0, src_a_i=0x2 or mode 11 -> err_o=1, done_o pulse one cycle after start, mem_req_o never asserted.
REQ-042 rst_i during WT_B of element 2 with a late rvalid after reset -> state IDLE, all outputs zero, no write issued; a new start then completes correctly.

Source files
------------

// File: rtl/vec_mac_pkg.sv
// Shared types and constants for the vector multiply-accumulate unit.
package vec_mac_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_WT_A,
    S_RD_B,
    S_WT_B,
    S_RD_D,
    S_WT_D,
    S_WR_D,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_OVWR = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/vec_mac_unit_sat.sv
// Final combine of the accumulator with the destination value: wrap-add,
// saturating add, or plain truncation depending on mode.
module vec_mac_sat
  import vec_mac_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ACC_W = 69
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [XLEN-1:0]  i_d,
  input  logic [1:0]       i_mode,
  output logic [XLEN-1:0]  o_final
);

  // One guard bit so acc + D can never wrap before the range test.
  localparam int SW = ACC_W + 1;

  logic [SW-1:0] w_sum;
  logic          w_fits;

  assign w_sum  = {i_acc[ACC_W-1], i_acc} + {{(SW-XLEN){i_d[XLEN-1]}}, i_d};
  // Representable in XLEN signed bits iff all bits from the XLEN-1 sign bit up agree.
  assign w_fits = (&w_sum[SW-1:XLEN-1]) | ~(|w_sum[SW-1:XLEN-1]);

  // Select the value written back to the destination.
  always_comb begin
    o_final = '0;
    case (i_mode)
      MODE_WRAP: o_final = w_sum[XLEN-1:0];
      MODE_SAT: begin
        if (w_fits)          o_final = w_sum[XLEN-1:0];
        else if (w_sum[SW-1]) o_final = {1'b1, {(XLEN-1){1'b0}}};
        else                  o_final = {1'b0, {(XLEN-1){1'b1}}};
      end
      MODE_OVWR: o_final = i_acc[XLEN-1:0];
      default:   o_final = '0;
    endcase
  end

endmodule

// File: rtl/vec_mac_unit.sv
// Vector dot-product engine: reads A[i], B[i] over a single-outstanding
// memory port, accumulates signed products, then combines with D and
// writes the result back to dst.
//
// state  | meaning
// IDLE   | waiting for start_i, operands captured on start
// RD_A   | read request for A[i] held until granted
// WT_A   | waiting for A[i] read data
// RD_B   | read request for B[i] held until granted
// WT_B   | waiting for B[i], product added into acc
// RD_D   | read request for destination value D
// WT_D   | waiting for D, final value computed
// WR_D   | write request of final value to dst
// DONE   | one cycle before the done_o pulse, back to IDLE
module vec_mac_unit
  import vec_mac_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = clog2(MAX_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] src_a_i,
  input  logic [ADDR_W-1:0] src_b_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [1:0]        mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [XLEN-1:0]   result_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int BYTES = XLEN / 8;
  localparam int ACC_W = 2 * XLEN + LEN_W;

  state_t             r_state;
  logic               r_done;
  logic               r_err;
  logic               r_req;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [XLEN-1:0]    r_result;
  logic [ACC_W-1:0]   r_acc;
  logic [LEN_W-1:0]   r_idx;
  logic [LEN_W-1:0]   r_len;
  logic [1:0]         r_mode;
  logic [ADDR_W-1:0]  r_src_a;
  logic [ADDR_W-1:0]  r_src_b;
  logic [ADDR_W-1:0]  r_dst;
  logic [XLEN-1:0]    r_a;

  logic               w_bad;
  logic [LEN_W-1:0]   w_idx_next;
  logic               w_last;
  logic [ADDR_W-1:0]  w_off;
  logic [ADDR_W-1:0]  w_off_next;
  logic [2*XLEN-1:0]  w_prod;
  logic [ACC_W-1:0]   w_acc_sum;
  logic [ACC_W-1:0]   w_sat_acc;
  logic [XLEN-1:0]    w_final;

  assign w_bad = (len_i == '0) || (len_i > LEN_W'(MAX_LEN)) || (mode_i == MODE_RSVD) ||
                 ((src_a_i % ADDR_W'(BYTES)) != '0) ||
                 ((src_b_i % ADDR_W'(BYTES)) != '0) ||
                 ((dst_i   % ADDR_W'(BYTES)) != '0);

  assign w_idx_next = r_idx + LEN_W'(1);
  assign w_last     = (w_idx_next == r_len);
  assign w_off      = ADDR_W'(r_idx) * ADDR_W'(BYTES);
  assign w_off_next = ADDR_W'(w_idx_next) * ADDR_W'(BYTES);

  // Sign-extended operands make the unsigned product equal the signed one.
  assign w_prod    = {{XLEN{r_a[XLEN-1]}}, r_a} *
                     {{XLEN{mem_rdata_i[XLEN-1]}}, mem_rdata_i};
  assign w_acc_sum = r_acc + {{LEN_W{w_prod[2*XLEN-1]}}, w_prod};

  // Overwrite mode leaves WT_B straight for WR_D, so it needs the sum that
  // includes the product arriving this cycle.
  assign w_sat_acc = (r_state == S_WT_B) ? w_acc_sum : r_acc;

  vec_mac_sat #(
    .XLEN  (XLEN),
    .ACC_W (ACC_W)
  ) u_sat (
    .i_acc   (w_sat_acc),
    .i_d     (mem_rdata_i),
    .i_mode  (r_mode),
    .o_final (w_final)
  );

  // Main sequencer; memory request fields are set on entry to RD_x/WR_D
  // and held until the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_len    <= '0;
      r_mode   <= MODE_WRAP;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_dst    <= '0;
      r_a      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_len   <= len_i;
            r_src_a <= src_a_i;
            r_src_b <= src_b_i;
            r_dst   <= dst_i;
            r_mode  <= mode_i;
            r_acc   <= '0;
            r_idx   <= '0;
            r_err   <= w_bad;
            if (w_bad) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD_A;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= src_a_i;
            end
          end
        end
        S_RD_A: if (mem_gnt_i) begin
          r_req   <= 1'b0;
          r_state <= S_WT_A;
        end
        S_WT_A: if (mem_rvalid_i) begin
          r_a     <= mem_rdata_i;
          r_req   <= 1'b1;
          r_addr  <= r_src_b + w_off;
          r_state <= S_RD_B;
        end
        S_RD_B: if (mem_gnt_i) begin
          r_req   <= 1'b0;
          r_state <= S_WT_B;
        end
        S_WT_B: if (mem_rvalid_i) begin
          r_acc <= w_acc_sum;
          r_req <= 1'b1;
          if (!w_last) begin
            r_idx   <= w_idx_next;
            r_addr  <= r_src_a + w_off_next;
            r_state <= S_RD_A;
          end else if (r_mode == MODE_OVWR) begin
            r_we    <= 1'b1;
            r_addr  <= r_dst;
            r_wdata <= w_final;
            r_state <= S_WR_D;
          end else begin
            r_addr  <= r_dst;
            r_state <= S_RD_D;
          end
        end
        S_RD_D: if (mem_gnt_i) begin
          r_req   <= 1'b0;
          r_state <= S_WT_D;
        end
        S_WT_D: if (mem_rvalid_i) begin
          r_req   <= 1'b1;
          r_we    <= 1'b1;
          r_wdata <= w_final;
          r_state <= S_WR_D;
        end
        S_WR_D: if (mem_gnt_i) begin
          r_req    <= 1'b0;
          r_we     <= 1'b0;
          r_result <= r_wdata;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign result_o    = r_result;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_vec_mac_unit.sv
// Directed bench for vec_mac_unit with a negedge-driven memory responder.
module tb_vec_mac_unit;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [4:0]  len_i;
  logic [31:0] src_a_i, src_b_i, dst_i;
  logic [1:0]  mode_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] result_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  vec_mac_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .dst_i(dst_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Shared state: main writes the config, responder writes the counters.
  logic [31:0] mem [0:255];
  logic [31:0] cur_dst;
  logic [31:0] hold_addr;
  int          rnd_dly;
  int          inject_req;
  int          wr_count, dst_reads, req_cycles, viol, held_count;
  logic [31:0] last_wr_addr, last_wr_data;

  int n_checks;
  int n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: random or zero grant/rvalid delay, checks request
  // stability and single-outstanding behaviour.
  initial begin : responder
    int ph, g_cnt, r_cnt, inj_seen;
    logic seen, c_we;
    logic [31:0] c_addr, c_wdata;
    ph = 0; g_cnt = 0; r_cnt = 0; inj_seen = 0; seen = 1'b0;
    c_we = 1'b0; c_addr = '0; c_wdata = '0;
    wr_count = 0; dst_reads = 0; req_cycles = 0; viol = 0; held_count = 0;
    last_wr_addr = '0; last_wr_data = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rst_i) begin
        ph = 0;
        seen = 1'b0;
      end else if (inj_seen != inject_req) begin
        inj_seen = inject_req;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h1234_5678;
      end else begin
        case (ph)
          0: if (mem_req_o) begin
            req_cycles++;
            if (!seen) begin
              seen = 1'b1;
              c_addr = mem_addr_o;
              c_we = mem_we_o;
              c_wdata = mem_wdata_o;
              g_cnt = rnd_dly ? $urandom_range(0, 5) : 0;
            end else if (mem_addr_o !== c_addr || mem_we_o !== c_we || mem_wdata_o !== c_wdata) begin
              viol++;
            end
            if (g_cnt == 0) begin
              mem_gnt_i = 1'b1;
              seen = 1'b0;
              if (c_we) begin
                wr_count++;
                last_wr_addr = c_addr;
                last_wr_data = c_wdata;
                ph = 2;
              end else begin
                if (c_addr == cur_dst) dst_reads++;
                r_cnt = rnd_dly ? $urandom_range(0, 5) : 0;
                if (c_addr == hold_addr) begin
                  held_count++;
                  ph = 3;
                end else begin
                  ph = 1;
                end
              end
            end else begin
              g_cnt--;
            end
          end
          1: begin
            if (mem_req_o) viol++;
            if (r_cnt == 0) begin
              mem_rvalid_i = 1'b1;
              mem_rdata_i = mem[c_addr[9:2]];
              ph = 0;
            end else begin
              r_cnt--;
            end
          end
          2: begin
            if (mem_req_o) viol++;
            ph = 0;
          end
          default: if (mem_req_o) viol++;
        endcase
      end
    end
  end

  typedef struct {
    logic [1:0]        mode;
    logic [4:0]        len;
    logic [31:0]       sa, sb, dst, d;
    logic [15:0][31:0] a, b;
    logic [31:0]       exp;
    int                cyc;
    logic              err;
  } vec_t;

  vec_t tv [12];
  vec_t rv;

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      if (i < int'(v.len)) begin
        mem[8'((v.sa >> 2) + i)] = v.a[i];
        mem[8'((v.sb >> 2) + i)] = v.b[i];
      end
    end
    mem[8'(v.dst >> 2)] = v.d;
    cur_dst = v.dst;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int wr0, rd0, rq0, vi0, cycles;
    logic got_done, busy_at_start;
    load_vec(v);
    wr0 = wr_count; rd0 = dst_reads; rq0 = req_cycles; vi0 = viol;
    @(negedge clk_i);
    len_i = v.len; src_a_i = v.sa; src_b_i = v.sb; dst_i = v.dst; mode_i = v.mode;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    busy_at_start = busy_o;
    got_done = 1'b0;
    cycles = 0;
    for (int c = 1; c <= 3000 && !got_done; c++) begin
      @(posedge clk_i);
      #1;
      if (done_o) begin
        got_done = 1'b1;
        cycles = c;
      end
    end
    check($sformatf("v%0d_busy", idx), 64'(busy_at_start), 64'(!v.err));
    check($sformatf("v%0d_done_seen", idx), 64'(got_done), 64'd1);
    if (v.cyc >= 0) check($sformatf("v%0d_cycles", idx), 64'(cycles), 64'(v.cyc));
    check($sformatf("v%0d_err", idx), 64'(err_o), 64'(v.err));
    @(posedge clk_i);
    #1;
    check($sformatf("v%0d_done_pulse", idx), 64'(done_o), 64'd0);
    if (!v.err) begin
      check($sformatf("v%0d_result", idx), 64'(result_o), 64'(v.exp));
      check($sformatf("v%0d_wr_count", idx), 64'(wr_count - wr0), 64'd1);
      check($sformatf("v%0d_wr_addr", idx), 64'(last_wr_addr), 64'(v.dst));
      check($sformatf("v%0d_wr_data", idx), 64'(last_wr_data), 64'(v.exp));
      check($sformatf("v%0d_protocol", idx), 64'(viol - vi0), 64'd0);
      if (v.mode == 2'b10) check($sformatf("v%0d_dst_reads", idx), 64'(dst_reads - rd0), 64'd0);
    end else begin
      check($sformatf("v%0d_req_cycles", idx), 64'(req_cycles - rq0), 64'd0);
      check($sformatf("v%0d_wr_count", idx), 64'(wr_count - wr0), 64'd0);
    end
  endtask

  function automatic vec_t base_vec();
    vec_t v;
    v.mode = 2'b00; v.len = 5'd1;
    v.sa = 32'h100; v.sb = 32'h200; v.dst = 32'h300; v.d = '0;
    v.a = '0; v.b = '0; v.exp = '0; v.cyc = -1; v.err = 1'b0;
    return v;
  endfunction

  initial begin : main
    longint acc;
    int ai, bi, di, h0;
    logic got_hold;
    n_checks = 0; n_err = 0;
    rnd_dly = 0; inject_req = 0;
    hold_addr = 32'hFFFF_FFFF; cur_dst = 32'hFFFF_FFFF;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_i = 1'b1; start_i = 1'b0; len_i = '0;
    src_a_i = '0; src_b_i = '0; dst_i = '0; mode_i = '0;

    for (int i = 0; i < 12; i++) tv[i] = base_vec();
    tv[0].len = 3; tv[0].a[0] = 1; tv[0].a[1] = 2; tv[0].a[2] = 3;
    tv[0].b[0] = 4; tv[0].b[1] = 5; tv[0].b[2] = 6; tv[0].d = 10;
    tv[0].exp = 32'd42; tv[0].cyc = 16;
    tv[1].mode = 2'b01; tv[1].len = 2; tv[1].a[0] = 32'h7FFF_FFFF; tv[1].a[1] = 32'h7FFF_FFFF;
    tv[1].b[0] = 2; tv[1].b[1] = 2; tv[1].exp = 32'h7FFF_FFFF; tv[1].cyc = 12;
    tv[2] = tv[1]; tv[2].mode = 2'b00; tv[2].exp = 32'hFFFF_FFFC;
    tv[3].mode = 2'b10; tv[3].a[0] = 32'hFFFF_FFFD; tv[3].b[0] = 7; tv[3].d = 100;
    tv[3].exp = 32'hFFFF_FFEB; tv[3].cyc = 6;
    tv[4].mode = 2'b01; tv[4].len = 2; tv[4].a[0] = 32'h8000_0000; tv[4].a[1] = 32'h8000_0000;
    tv[4].b[0] = 32'h7FFF_FFFF; tv[4].b[1] = 32'h7FFF_FFFF; tv[4].exp = 32'h8000_0000; tv[4].cyc = 12;
    tv[5].mode = 2'b01; tv[5].a[0] = 5; tv[5].b[0] = 32'hFFFF_FFFE; tv[5].d = 32'hFFFF_FFFD;
    tv[5].exp = 32'hFFFF_FFF3; tv[5].cyc = 8;
    tv[6].mode = 2'b10; tv[6].len = 2; tv[6].a[0] = 32'h1_0000; tv[6].a[1] = 32'h1_0000;
    tv[6].b[0] = 32'h1_0000; tv[6].b[1] = 3; tv[6].exp = 32'h0003_0000; tv[6].cyc = 10;
    tv[7].len = 0;             tv[7].err = 1'b1;  tv[7].cyc = 1;
    tv[8].sa = 32'h102;        tv[8].err = 1'b1;  tv[8].cyc = 1;
    tv[9].mode = 2'b11;        tv[9].err = 1'b1;  tv[9].cyc = 1;
    tv[10].len = 17;           tv[10].err = 1'b1; tv[10].cyc = 1;
    tv[11].dst = 32'h303;      tv[11].err = 1'b1; tv[11].cyc = 1;

    repeat (3) @(negedge clk_i);
    check("rst_flags", 64'({busy_o, done_o, err_o, mem_req_o, mem_we_o}), 64'd0);
    check("rst_data", {mem_addr_o, mem_wdata_o}, 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 12; i++) run_vec(i, tv[i]);

    // Random delays, full-length vector, wrap and overwrite modes.
    rnd_dly = 1;
    rv = base_vec();
    rv.len = 16;
    rv.d = $urandom;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      rv.a[i] = $urandom;
      rv.b[i] = $urandom;
      ai = rv.a[i];
      bi = rv.b[i];
      acc = acc + longint'(ai) * longint'(bi);
    end
    di = rv.d;
    rv.exp = 32'(acc + longint'(di));
    run_vec(20, rv);
    rv.mode = 2'b10;
    rv.exp = 32'(acc);
    run_vec(21, rv);
    rnd_dly = 0;

    // Reset while waiting on B[2]; a stale grant/rvalid afterwards must be ignored.
    load_vec(tv[0]);
    hold_addr = tv[0].sb + 32'd8;
    h0 = held_count;
    h0 = h0 + 0;
    @(negedge clk_i);
    len_i = tv[0].len; src_a_i = tv[0].sa; src_b_i = tv[0].sb; dst_i = tv[0].dst; mode_i = 2'b00;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    got_hold = 1'b0;
    for (int c = 0; c < 200 && !got_hold; c++) begin
      @(negedge clk_i);
      if (held_count != h0) got_hold = 1'b1;
    end
    check("hold_reached", 64'(got_hold), 64'd1);
    check("hold_busy", 64'(busy_o), 64'd1);
    h0 = wr_count;
    rst_i = 1'b1;
    #1;
    check("midrst_flags", 64'({busy_o, done_o, err_o, mem_req_o, mem_we_o}), 64'd0);
    check("midrst_data", {mem_addr_o, mem_wdata_o}, 64'd0);
    check("midrst_result", 64'(result_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    hold_addr = 32'hFFFF_FFFF;
    @(negedge clk_i);
    inject_req = inject_req + 1;
    repeat (6) @(negedge clk_i);
    check("late_flags", 64'({busy_o, done_o, err_o, mem_req_o, mem_we_o}), 64'd0);
    check("late_result", 64'(result_o), 64'd0);
    check("late_no_write", 64'(wr_count - h0), 64'd0);
    run_vec(30, tv[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
